// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/mul-div stalls, mul/div busy scoreboard.
// Optional stall-cause performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic                  BranchD,
  input  logic                  MulDivReadD,
  input  logic                  MulDivStartD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteE,
  input  logic                  MulDivStartE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic                  MemtoRegM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushE,
  output logic                  MulDivBusy
`ifdef HAZARD_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           lw_stall_cnt,
  output logic [31:0]           br_stall_cnt,
  output logic [31:0]           md_stall_cnt
`endif
);

  logic [CNT_W-1:0] cnt;
  logic             lwstall;
  logic             branchstall;
  logic             mdstall;
  logic             stall;
  logic             hit_m_rs_e, hit_w_rs_e, hit_m_rt_e, hit_w_rt_e;
  logic             br_e_hit, br_m_hit;

  // Register 0 never matches, so every hit qualifies the source id as nonzero.
  always_comb begin
    hit_m_rs_e = RegWriteM && (RsE != '0) && (WriteRegM == RsE);
    hit_w_rs_e = RegWriteW && (RsE != '0) && (WriteRegW == RsE);
    hit_m_rt_e = RegWriteM && (RtE != '0) && (WriteRegM == RtE);
    hit_w_rt_e = RegWriteW && (RtE != '0) && (WriteRegW == RtE);

    ForwardAE = hit_m_rs_e ? 2'b10 : (hit_w_rs_e ? 2'b01 : 2'b00);
    ForwardBE = hit_m_rt_e ? 2'b10 : (hit_w_rt_e ? 2'b01 : 2'b00);
    ForwardAD = RegWriteM && (RsD != '0) && (WriteRegM == RsD);
    ForwardBD = RegWriteM && (RtD != '0) && (WriteRegM == RtD);
  end

  always_comb begin
    lwstall  = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    br_e_hit = RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    br_m_hit = MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
    branchstall = BranchD && (br_e_hit || br_m_hit);
    mdstall  = (MulDivReadD || MulDivStartD) && (MulDivBusy || MulDivStartE);
    stall    = lwstall || branchstall || mdstall;
    StallF   = stall;
    StallD   = stall;
    FlushE   = stall;
  end

  // A new issue while busy reloads rather than extends the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (MulDivStartE) begin
      cnt <= CNT_W'(MULDIV_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign MulDivBusy = (cnt != '0);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lw_stall_cnt <= '0;
      br_stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else if (perf_clr) begin
      lw_stall_cnt <= '0;
      br_stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (lwstall && (lw_stall_cnt != '1))     lw_stall_cnt <= lw_stall_cnt + 32'd1;
      if (branchstall && (br_stall_cnt != '1)) br_stall_cnt <= br_stall_cnt + 32'd1;
      if (mdstall && (md_stall_cnt != '1))     md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (mul/div latency 4); expected
// outputs are queued when inputs are driven and compared at the following falling edge.
module tb_hazard_scoreboard_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, MulDivReadD, MulDivStartD;
  logic       MemtoRegE, RegWriteE, MulDivStartE;
  logic       MemtoRegM, RegWriteM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MulDivBusy;
`ifdef HAZARD_PERF_EN
  logic        perf_clr;
  logic [31:0] lw_stall_cnt, br_stall_cnt, md_stall_cnt;
`endif

  always #5 clock = ~clock;

  hazard_scoreboard_unit #(
    .REG_ADDR_W(5),
    .MULDIV_LATENCY(4),
    .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .MulDivReadD(MulDivReadD), .MulDivStartD(MulDivStartD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MulDivStartE(MulDivStartE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MulDivBusy(MulDivBusy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_clr(perf_clr),
    .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic [1:0]  fae, fbe;
    logic        fad, fbd, stall, busy;
    bit          busy_only;
    bit          perf_chk;
    logic [31:0] lw, br, md;
  } exp_t;

  exp_t        q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    BranchD = 1'b0; MulDivReadD = 1'b0; MulDivStartD = 1'b0;
    MemtoRegE = 1'b0; RegWriteE = 1'b0; MulDivStartE = 1'b0;
    MemtoRegM = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
`ifdef HAZARD_PERF_EN
    perf_clr = 1'b0;
`endif
  endtask

  task automatic randomize_inputs();
    RsD = 5'($urandom_range(31, 0)); RtD = 5'($urandom_range(31, 0));
    RsE = 5'($urandom_range(31, 0)); RtE = 5'($urandom_range(31, 0));
    WriteRegE = 5'($urandom_range(31, 0));
    WriteRegM = 5'($urandom_range(31, 0));
    WriteRegW = 5'($urandom_range(31, 0));
    BranchD = 1'($urandom_range(1, 0)); MulDivReadD = 1'($urandom_range(1, 0));
    MulDivStartD = 1'($urandom_range(1, 0)); MemtoRegE = 1'($urandom_range(1, 0));
    RegWriteE = 1'($urandom_range(1, 0)); MulDivStartE = 1'($urandom_range(1, 0));
    MemtoRegM = 1'($urandom_range(1, 0)); RegWriteM = 1'($urandom_range(1, 0));
    RegWriteW = 1'($urandom_range(1, 0));
`ifdef HAZARD_PERF_EN
    perf_clr = 1'($urandom_range(1, 0));
`endif
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] fae, input logic [1:0] fbe,
                            input logic fad, input logic fbd, input logic stall, input logic busy);
    exp_t e;
    e.tag = tag; e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd;
    e.stall = stall; e.busy = busy; e.busy_only = 1'b0;
    e.perf_chk = 1'b0; e.lw = '0; e.br = '0; e.md = '0;
    q.push_back(e);
  endtask

  task automatic expect_busy(input string tag, input logic busy);
    expect_out(tag, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, busy);
    q[q.size()-1].busy_only = 1'b1;
  endtask

  task automatic expect_perf(input logic [31:0] lw, input logic [31:0] br, input logic [31:0] md);
    q[q.size()-1].perf_chk = 1'b1;
    q[q.size()-1].lw = lw;
    q[q.size()-1].br = br;
    q[q.size()-1].md = md;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check();
    exp_t e;
    @(negedge clock);
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp({e.tag, ".busy"}, 32'(MulDivBusy), 32'(e.busy));
      if (!e.busy_only) begin
        cmp({e.tag, ".ForwardAE"}, 32'(ForwardAE), 32'(e.fae));
        cmp({e.tag, ".ForwardBE"}, 32'(ForwardBE), 32'(e.fbe));
        cmp({e.tag, ".ForwardAD"}, 32'(ForwardAD), 32'(e.fad));
        cmp({e.tag, ".ForwardBD"}, 32'(ForwardBD), 32'(e.fbd));
        cmp({e.tag, ".StallF"}, 32'(StallF), 32'(e.stall));
        cmp({e.tag, ".StallD"}, 32'(StallD), 32'(e.stall));
        cmp({e.tag, ".FlushE"}, 32'(FlushE), 32'(e.stall));
      end
`ifdef HAZARD_PERF_EN
      if (e.perf_chk) begin
        cmp({e.tag, ".lw_cnt"}, lw_stall_cnt, e.lw);
        cmp({e.tag, ".br_cnt"}, br_stall_cnt, e.br);
        cmp({e.tag, ".md_cnt"}, md_stall_cnt, e.md);
      end
`endif
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();

    // Reset held with random inputs: the busy counter cannot load.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); randomize_inputs();
      expect_busy($sformatf("rst_rand%0d", i), 1'b0);
      check();
    end
    next_cycle(); clear_inputs(); reset_n = 1'b1;
    expect_out("rst_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

    // Forwarding: M over W, register 0 excluded.
    next_cycle(); clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8;
    expect_out("fwd_m_prio", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); RsE = 5'd0;
    expect_out("fwd_r0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs();
    RegWriteW = 1'b1; WriteRegW = 5'd8; RtE = 5'd8; RegWriteM = 1'b1; WriteRegM = 5'd7;
    expect_out("fwd_w_only", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd3;
    RsD = 5'd3; RtD = 5'd3; RtE = 5'd3; RsE = 5'd3;
    expect_out("fwd_all_m", 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd0; RsD = 5'd0; RtD = 5'd0;
    expect_out("fwd_d_r0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

    // Load-use.
    next_cycle(); clear_inputs(); MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
    expect_out("lw_hit", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check();
    next_cycle(); MemtoRegE = 1'b0;
    expect_out("lw_gone", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs(); MemtoRegE = 1'b1; RtE = 5'd0;
    expect_out("lw_r0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

    // Branch in decode.
    next_cycle(); clear_inputs(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd4; RtD = 5'd4;
    expect_out("br_e", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check();
    next_cycle(); RegWriteE = 1'b0; WriteRegE = 5'd0;
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd4;
    expect_out("br_load_m", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check();
    next_cycle(); MemtoRegM = 1'b0;
    expect_out("br_alu_m", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0;
    expect_out("br_r0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs(); RegWriteE = 1'b1; WriteRegE = 5'd4; RtD = 5'd4;
    expect_out("br_nobranch", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

    // Mul/div latency 4 with mfhi held in decode.
    next_cycle(); clear_inputs(); MulDivReadD = 1'b1; MulDivStartE = 1'b1;
    expect_out("md_c0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check();
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); MulDivStartE = 1'b0;
      expect_out($sformatf("md_c%0d", c), 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      check();
    end
    next_cycle();
    expect_out("md_c5", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

    // Async reset mid-busy kills mdstall immediately.
    next_cycle(); clear_inputs(); MulDivStartE = 1'b1;
    expect_out("md_issue_noread", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); MulDivStartE = 1'b0; MulDivStartD = 1'b1;
    expect_out("md_startd_busy", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check();
    next_cycle(); reset_n = 1'b0;
    expect_out("md_async_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    next_cycle(); clear_inputs(); reset_n = 1'b1;

    // Simultaneous causes.
    next_cycle(); clear_inputs();
    MemtoRegE = 1'b1; RtE = 5'd6; RsD = 5'd6; BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd6;
    MulDivReadD = 1'b1; MulDivStartE = 1'b1;
    expect_out("multi_cause", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check();
    for (int c = 0; c < 5; c++) begin
      next_cycle(); clear_inputs();
    end
    expect_out("drain", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();

`ifdef HAZARD_PERF_EN
    next_cycle(); clear_inputs(); perf_clr = 1'b1;
    expect_out("perf_clr0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    for (int c = 0; c < 3; c++) begin
      next_cycle(); clear_inputs(); MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
      expect_out($sformatf("perf_lw%0d", c), 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      check();
    end
    next_cycle(); clear_inputs(); MulDivStartD = 1'b1; MulDivStartE = 1'b1;
    expect_out("perf_md0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check();
    next_cycle(); clear_inputs(); MulDivReadD = 1'b1;
    expect_out("perf_md1", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check();
    next_cycle(); clear_inputs();
    expect_out("perf_totals", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_perf(32'd3, 32'd0, 32'd2);
    check();
    next_cycle(); perf_clr = 1'b1;
    expect_out("perf_clr_pending", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_perf(32'd3, 32'd0, 32'd2);
    check();
    next_cycle(); perf_clr = 1'b0;
    expect_out("perf_cleared", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_perf(32'd0, 32'd0, 32'd0);
    check();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the fixed-wire hazard stubs in the five-stage MIPS pipeline top level. It generates E-stage and D-stage forwarding selects, plus StallF, StallD and FlushE. Beyond plain forwarding, it detects load-use and branch-in-decode hazards. A latency counter scoreboards a multi-cycle mul/div unit, so HI/LO reads and back-to-back mul/div issue stall correctly. It sits beside the decode and execute stages and drives the fetch, decode and execute pipeline controls.

Parameters:
REG_ADDR_W, 5, register-id width; register 0 is hardwired zero and never forwarded or matched.
MULDIV_LATENCY, 32, cycles mul/div stays busy after issue from E; legal range 1..255.
CNT_W, 8, width of the busy counter; must satisfy 2**CNT_W > MULDIV_LATENCY.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
RsD, RtD  in  REG_ADDR_W  decode source ids
BranchD  in  1  decode holds a branch compared in D
MulDivReadD  in  1  decode holds mfhi/mflo
MulDivStartD  in  1  decode holds mult/div
RsE, RtE, WriteRegE  in  REG_ADDR_W  execute ids
MemtoRegE, RegWriteE, MulDivStartE  in  1  execute controls; MulDivStartE is mul/div issuing this cycle
WriteRegM  in  REG_ADDR_W  memory-stage destination
MemtoRegM, RegWriteM  in  1  memory controls
WriteRegW  in  REG_ADDR_W  writeback destination
RegWriteW  in  1  writeback control
ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUOutM
ForwardAD, ForwardBD  out  1  1 selects ALUOutM for the branch comparator
StallF, StallD  out  1  1 holds the PC and the fetch/decode register
FlushE  out  1  1 clears the decode/execute register (active-high flush)
MulDivBusy  out  1  mul/div unit occupied

Behaviour:
- Clock port is clock; reset is asynchronous, active-low, on reset_n.
- Forwarding is combinational; a match requires the source id to be nonzero.
- ForwardAE = 10 if RegWriteM && WriteRegM==RsE. Else 01 if RegWriteW && WriteRegW==RsE. Else 00. M has priority over W. ForwardBE is the same with RtE.
- ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD is the same with RtD.
- lwstall = MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && (either of two conditions matches RsD or RtD, nonzero id):
  - RegWriteE && WriteRegE matches;
  - MemtoRegM && WriteRegM matches.
- Busy counter cnt (CNT_W bits):
  - reset gives 0;
  - MulDivStartE loads MULDIV_LATENCY;
  - otherwise decrements if nonzero, holds at 0.
  - MulDivBusy = (cnt!=0), registered-state based.
- MulDivStartE while already busy reloads the counter. Legal pipelines never do this because D is stalled.
- mdstall = (MulDivReadD || MulDivStartD) && (MulDivBusy || MulDivStartE).
- stall = lwstall | branchstall | mdstall.
- StallF = StallD = FlushE = stall, combinational, same cycle.
- Simultaneous causes OR together; no cause masks another.
- Reset value of every output is 0 when all data inputs are 0: cnt=0, so MulDivBusy=0.
- Reset asserted mid-operation clears cnt immediately (asynchronously); mdstall drops in the same cycle.
- MULDIV_LATENCY=1: busy for exactly one cycle after the issue edge.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds a clear input perf_clr (1) and three 32-bit outputs: lw_stall_cnt, br_stall_cnt, md_stall_cnt.
- Each counter increments on every clock edge where its cause is asserted. Causes are counted independently, so one cycle can bump several counters.
- Each counter saturates at 0xFFFFFFFF. All reset to 0 on reset_n or on synchronous perf_clr.
- When not defined, none of these ports or registers exist; all other behaviour is identical.

Test Plan:
- Reset asserted with random inputs, then released with all inputs 0 -> all outputs 0, MulDivBusy=0.
- RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 -> ForwardAE=10. Then RsE=0 with the same matches -> ForwardAE=00.
- MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1 for one cycle. Next cycle with MemtoRegE=0 -> all 0.
- BranchD=1, RegWriteE=1, WriteRegE=4, RtD=4 -> stall=1. With the producer then in M as MemtoRegM=1, WriteRegM=4 -> stall=1. As an ALU op in M (RegWriteM=1, MemtoRegM=0) -> stall=0 and ForwardBD=1.
- MULDIV_LATENCY=4: pulse MulDivStartE at edge 0, hold MulDivReadD=1 -> MulDivBusy=1 for edges 1-4 and stall=1 from cycle 0 through 4. At cycle 5, stall=0.
- HAZARD_PERF_EN: 3 load-use cycles then 2 mdstall cycles -> lw_stall_cnt=3, md_stall_cnt=2, br_stall_cnt=0. perf_clr -> all counters 0.
